inst_mem_seq: RTL and testbench

INST_MEM_SEQ -- requirements
Module: inst_mem_seq

---
 rtl/inst_mem_seq.sv | 122 ++++++++++++
 tb/tb_inst_mem_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_seq.sv
// Loadable instruction memory: IDLE/LOAD sequencer with registered, range-checked reads.
// Optional stored even-parity per word when INST_MEM_PARITY_EN is defined.
module inst_mem_seq #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    input  logic              ld_start,
    input  logic              ld_we,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              busy,
`ifdef INST_MEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              ld_done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
`ifdef INST_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state, state_nxt;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [CNT_W-1:0]  loaded_cnt;
    logic              wr, wr_exit, rd_fire, in_range;
    logic [CMP_W-1:0]  addr_ext, cnt_ext;
    logic [MEM_W-1:0]  wdata, rword;

    assign wr       = (state == LOAD) && ld_we;
    assign wr_exit  = wr && (ld_last || wr_ptr == AW'(DEPTH - 1));
    assign rd_fire  = (state == IDLE) && rd_req;
    // Compare at a common width so addresses >= DEPTH never alias.
    assign addr_ext = CMP_W'(rd_addr);
    assign cnt_ext  = CMP_W'(loaded_cnt);
    assign in_range = addr_ext < cnt_ext;
    assign rword    = mem[addr_ext[AW-1:0]];

`ifdef INST_MEM_PARITY_EN
    assign wdata = {^ld_data, ld_data};
`else
    assign wdata = ld_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (ld_start) state_nxt = LOAD;
            LOAD: if (wr_exit)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            loaded_cnt <= '0;
            ld_done    <= 1'b0;
        end else begin
            ld_done <= wr_exit;
            if ((state == IDLE) && ld_start) begin
                wr_ptr     <= '0;
                loaded_cnt <= '0;
            end else if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (loaded_cnt != CNT_W'(DEPTH))
                    loaded_cnt <= loaded_cnt + CNT_W'(1);
            end
        end
    end

    // Storage is deliberately not reset; loaded_cnt gates visibility.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
`ifdef INST_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= in_range ? rword[DATA_W-1:0] : '0;
                rd_err  <= !in_range;
`ifdef INST_MEM_PARITY_EN
                parity_err <= in_range &&
                    (rword[DATA_W] != ^rword[DATA_W-1:0]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_seq.sv
// Scoreboard bench for inst_mem_seq: randomized and directed traffic
// against a queue/array model of load and read behaviour.
module tb_inst_mem_seq;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              e;
        logic              p;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              ld_start = 1'b0;
    logic              ld_we = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
    logic              busy;
    logic              ld_done;
`ifdef INST_MEM_PARITY_EN
    logic              parity_err;
`endif

    inst_mem_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
        .ld_start(ld_start), .ld_we(ld_we), .ld_data(ld_data),
        .ld_last(ld_last), .busy(busy),
`ifdef INST_MEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .ld_done(ld_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    exp_t q[$];
    exp_t last_exp = '{d: '0, e: 1'b0, p: 1'b0};

    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_flip [DEPTH];
    int                m_cnt = 0;
    int                m_ptr = 0;
    bit                m_busy = 0;

    logic [DATA_W-1:0] prog [8] = '{32'h10005555, 32'h0C00AAAA, 32'h10800000,
                                    32'h0C800010, 32'h10A08000, 32'h0CA00000,
                                    32'h38202000, 32'h08250000};

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, x);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rd_valid", 64'(rd_valid), 64'(0));
            end else begin
                e = q.pop_front();
                chk("rd_data", 64'(rd_data), 64'(e.d));
                chk("rd_err", 64'(rd_err), 64'(e.e));
`ifdef INST_MEM_PARITY_EN
                chk("parity_err", 64'(parity_err), 64'(e.p));
`endif
                last_exp = e;
            end
        end else begin
            chk("hold_data", 64'(rd_data), 64'(last_exp.d));
            chk("hold_err", 64'(rd_err), 64'(last_exp.e));
        end
    end

    // One clock of stimulus; model applies the behavioural rules directly.
    task automatic cyc(input bit req, input logic [ADDR_W-1:0] addr,
                       input bit st, input bit we,
                       input logic [DATA_W-1:0] d, input bit last);
        exp_t e;
        bit ex;
        ex = 0;
        rd_req = req; rd_addr = addr; ld_start = st;
        ld_we = we; ld_data = d; ld_last = last;
        if (!m_busy) begin
            if (req) begin
                if (addr < 32'(m_cnt))
                    e = '{d: m_mem[addr], e: 1'b0, p: m_flip[addr]};
                else
                    e = '{d: '0, e: 1'b1, p: 1'b0};
                q.push_back(e);
            end
            if (st) begin
                m_busy = 1; m_ptr = 0; m_cnt = 0;
            end
        end else if (we) begin
            m_mem[m_ptr] = d;
            m_flip[m_ptr] = 0;
            m_ptr++;
            if (m_cnt < DEPTH) m_cnt++;
            if (last || m_ptr == DEPTH) begin
                m_busy = 0; ex = 1;
            end
        end
        @(negedge clk);
        chk("busy", 64'(busy), 64'(m_busy));
        chk("ld_done", 64'(ld_done), 64'(ex));
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, '0, 0);
    endtask

    task automatic reset_dut();
        #2;
        rst_n = 1'b0;
        rd_req = 0; ld_start = 0; ld_we = 0; ld_last = 0;
        m_busy = 0; m_cnt = 0; m_ptr = 0;
        q.delete();
        last_exp = '{d: '0, e: 1'b0, p: 1'b0};
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ld_done", 64'(ld_done), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_err", 64'(rd_err), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_flip[i] = 0;
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        reset_dut();

        cyc(1, 0, 0, 0, '0, 0);
        idle();

        cyc(0, 0, 1, 0, '0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, prog[i], i == 7);
        for (int a = 0; a <= 8; a++) cyc(1, 32'(a), 0, 0, '0, 0);
        idle();

        cyc(1, 3, 1, 0, '0, 0);
        cyc(1, 5, 0, 1, 32'hA5A5_0001, 0);
        cyc(1, 2, 1, 0, '0, 0);
        for (int i = 0; i < 18; i++)
            cyc(i % 3 == 0, 32'(i), 0, 1, $urandom, 0);
        cyc(1, 15, 0, 0, '0, 0);
        cyc(1, 16, 0, 0, '0, 0);
        cyc(1, 18, 0, 0, '0, 0);
        cyc(1, 32'hFFFF_FFFF, 0, 0, '0, 0);
        cyc(1, 2, 0, 0, '0, 0);
        idle();

        cyc(0, 0, 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, $urandom, 0);
        reset_dut();
        cyc(1, 0, 0, 0, '0, 0);
        idle();

        for (int n = 0; n < 400; n++) begin
            int r;
            logic [ADDR_W-1:0] a;
            r = $urandom_range(0, 199);
            if (r == 199) begin
                reset_dut();
            end else begin
                a = ($urandom_range(0, 9) != 0) ? 32'($urandom_range(0, DEPTH + 2)) : $urandom;
                cyc($urandom_range(0, 1) == 1, a, r < 8,
                    $urandom_range(0, 2) != 0, $urandom,
                    $urandom_range(0, 7) == 0);
            end
        end
        for (int i = 0; i < DEPTH + 2 && m_busy; i++) cyc(0, 0, 0, 1, $urandom, 0);
        idle();

`ifdef INST_MEM_PARITY_EN
        cyc(0, 0, 1, 0, '0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, prog[i], i == 3);
        idle();
        dut.mem[2][DATA_W] = ~dut.mem[2][DATA_W];
        m_flip[2] = 1;
        cyc(1, 2, 0, 0, '0, 0);
        cyc(1, 1, 0, 0, '0, 0);
        cyc(1, 20, 0, 0, '0, 0);
        idle();
`endif

        idle();
        idle();
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
